// File: rtl/oric_tap_player.sv
// rtl/oric_tap_player.sv - TAP image buffer and Oric cassette waveform player
// Optional TAP_SLOW_EN adds the slow_mode input and the slow cassette encoding.
module oric_tap_player #(
  parameter int ADDR_W     = 16,
  parameter int HALF_CYC   = 2496,
  parameter int STOP_BITS  = 4,
  parameter int LEAD_BYTES = 0
) (
  input  logic              clk_sys,
  input  logic              I_RESET,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W:0]   dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              play,
  input  logic              stop,
  input  logic              motor,
`ifdef TAP_SLOW_EN
  input  logic              slow_mode,
`endif
  output logic              tape_out,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] rd_ptr
);
  localparam int TW = $clog2(3*HALF_CYC+1);
  localparam logic [TW-1:0] T1 = TW'(HALF_CYC-1);
  localparam logic [TW-1:0] T2 = TW'(2*HALF_CYC-1);
  localparam logic [TW-1:0] T3 = TW'(3*HALF_CYC-1);
  localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS-1);
  localparam logic [15:0] LEAD_INIT = 16'(LEAD_BYTES);

  typedef enum logic [2:0] {IDLE, LOAD, FETCH, START, DATA, PARITY, STOP} state_t;
  state_t state, state_d;

  logic [7:0]        mem [2**ADDR_W];
  logic [7:0]        ram_q;
  logic [ADDR_W-1:0] ram_addr, ptr_d;
  logic [ADDR_W:0]   length, length_d;
  logic [TW-1:0]     timer, timer_d;
  logic              phase_lo, phase_lo_d;
  logic [3:0]        reps, reps_d, stop_cnt, stop_d;
  logic [2:0]        bit_cnt, bit_d;
  logic [7:0]        byte_reg, byte_d;
  logic [15:0]       lead_cnt, lead_d;
  logic              tape_d, ovf_d, done_d, slow, slow_d, slow_sample;
  logic              play_q, dl_q, new_cell, cur, nxt;

`ifdef TAP_SLOW_EN
  assign slow_sample = slow_mode;
`else
  assign slow_sample = 1'b0;
`endif

  function automatic logic cell_bit(state_t st, logic [7:0] b, logic [2:0] idx);
    case (st)
      DATA:    cell_bit = b[idx];
      PARITY:  cell_bit = ~^b;
      STOP:    cell_bit = 1'b1;
      default: cell_bit = 1'b0;
    endcase
  endfunction

  function automatic logic [TW-1:0] hi_load(logic b, logic s);
    return (s && !b) ? T2 : T1;
  endfunction

  function automatic logic [TW-1:0] lo_load(logic b, logic s);
    if (b) return T1;
    return s ? T2 : T3;
  endfunction

  function automatic logic [3:0] rep_load(logic b, logic s);
    if (!s) return 4'd1;
    return b ? 4'd8 : 4'd4;
  endfunction

  // Throughout STOP the read port already points at the next byte, so it is ready at frame end.
  assign ram_addr = (state == STOP && lead_cnt == '0) ? rd_ptr + 1'b1 : rd_ptr;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk_sys) begin
    if (state == LOAD && dl_wr && !dl_addr[ADDR_W]) mem[dl_addr[ADDR_W-1:0]] <= dl_data;
    ram_q <= mem[ram_addr];
  end

  always_comb begin
    state_d    = state;
    timer_d    = timer;
    phase_lo_d = phase_lo;
    reps_d     = reps;
    bit_d      = bit_cnt;
    stop_d     = stop_cnt;
    byte_d     = byte_reg;
    lead_d     = lead_cnt;
    ptr_d      = rd_ptr;
    tape_d     = tape_out;
    length_d   = length;
    ovf_d      = overflow;
    slow_d     = slow;
    done_d     = 1'b0;
    new_cell   = 1'b0;
    cur        = cell_bit(state, byte_reg, bit_cnt);
    if (dl_active && !dl_q) begin
      state_d  = LOAD;
      length_d = '0;
      ovf_d    = 1'b0;
      tape_d   = 1'b0;
      ptr_d    = '0;
    end else if (state == LOAD) begin
      if (dl_wr) begin
        if (dl_addr[ADDR_W]) ovf_d = 1'b1;
        else if (dl_addr + 1'b1 > length) length_d = dl_addr + 1'b1;
      end
      if (!dl_active) state_d = IDLE;
    end else if (state == IDLE) begin
      if (play && !play_q && length != '0 && !stop && !dl_active) begin
        state_d = FETCH;
        ptr_d   = '0;
        lead_d  = LEAD_INIT;
      end
    end else if (stop) begin
      state_d = IDLE;
      tape_d  = 1'b0;
      ptr_d   = '0;
    end else if (motor) begin
      if (state == FETCH) begin
        byte_d   = (lead_cnt != '0) ? 8'h16 : ram_q;
        slow_d   = slow_sample;
        state_d  = START;
        new_cell = 1'b1;
      end else if (timer != '0) begin
        timer_d = timer - 1'b1;
      end else if (!phase_lo) begin
        phase_lo_d = 1'b1;
        tape_d     = 1'b0;
        timer_d    = lo_load(cur, slow);
      end else if (reps > 4'd1) begin
        reps_d     = reps - 4'd1;
        phase_lo_d = 1'b0;
        tape_d     = 1'b1;
        timer_d    = hi_load(cur, slow);
      end else begin
        new_cell = 1'b1;
        case (state)
          START:  begin state_d = DATA; bit_d = 3'd0; end
          DATA:   if (bit_cnt == 3'd7) state_d = PARITY; else bit_d = bit_cnt + 3'd1;
          PARITY: begin state_d = STOP; stop_d = 4'd0; end
          default: begin
            if (stop_cnt != LAST_STOP) begin
              stop_d = stop_cnt + 4'd1;
            end else begin
              state_d = START;
              if (lead_cnt != '0) begin
                lead_d = lead_cnt - 16'd1;
                byte_d = (lead_cnt != 16'd1) ? 8'h16 : ram_q;
              end else if ({1'b0, rd_ptr} == length - 1'b1) begin
                state_d  = IDLE;
                done_d   = 1'b1;
                ptr_d    = '0;
                new_cell = 1'b0;
                tape_d   = 1'b0;
              end else begin
                ptr_d  = rd_ptr + 1'b1;
                byte_d = ram_q;
              end
            end
          end
        endcase
      end
    end
    nxt = cell_bit(state_d, byte_d, bit_d);
    if (new_cell) begin
      tape_d     = 1'b1;
      phase_lo_d = 1'b0;
      timer_d    = hi_load(nxt, slow_d);
      reps_d     = rep_load(nxt, slow_d);
    end
  end

  always_ff @(posedge clk_sys or negedge I_RESET) begin
    if (!I_RESET) begin
      state    <= IDLE;
      timer    <= '0;
      phase_lo <= 1'b0;
      reps     <= 4'd0;
      bit_cnt  <= 3'd0;
      stop_cnt <= 4'd0;
      byte_reg <= 8'h00;
      lead_cnt <= '0;
      rd_ptr   <= '0;
      tape_out <= 1'b0;
      length   <= '0;
      overflow <= 1'b0;
      slow     <= 1'b0;
      done     <= 1'b0;
      play_q   <= 1'b0;
      dl_q     <= 1'b0;
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      phase_lo <= phase_lo_d;
      reps     <= reps_d;
      bit_cnt  <= bit_d;
      stop_cnt <= stop_d;
      byte_reg <= byte_d;
      lead_cnt <= lead_d;
      rd_ptr   <= ptr_d;
      tape_out <= tape_d;
      length   <= length_d;
      overflow <= ovf_d;
      slow     <= slow_d;
      done     <= done_d;
      play_q   <= play;
      dl_q     <= dl_active;
    end
  end
endmodule

// File: tb/tb_oric_tap_player.sv
// tb/tb_oric_tap_player.sv - self-checking bench for oric_tap_player
// Waveforms are compared sample-by-sample against a queue built from the cassette framing rules.
module tb_oric_tap_player;
  localparam int AW = 4;
  localparam int H  = 4;
  localparam int SB = 4;

  logic          clk_sys = 1'b0;
  logic          I_RESET = 1'b0;
  logic          dl_active = 1'b0, dl_wr = 1'b0, play = 1'b0, stop = 1'b0, motor = 1'b1;
  logic [AW:0]   dl_addr = '0;
  logic [7:0]    dl_data = 8'h00;
  logic          tape_out, busy, done, overflow;
  logic [AW-1:0] rd_ptr;

  int n_vec = 0, n_fail = 0;
  bit exp_wave[$];
  bit cap_tape[$];
  int cap_ptr[$];
  bit timed_out;
  int extra_done;
  logic busy_at_done;

  typedef struct {
    logic [7:0] data;
    bit         par;
    int         cycles;
  } vec_t;
  vec_t tbl[6];

  always #5 clk_sys = ~clk_sys;

  oric_tap_player #(.ADDR_W(AW), .HALF_CYC(H), .STOP_BITS(SB), .LEAD_BYTES(0)) dut (
    .clk_sys(clk_sys), .I_RESET(I_RESET), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .play(play), .stop(stop), .motor(motor),
`ifdef TAP_SLOW_EN
    .slow_mode(1'b0),
`endif
    .tape_out(tape_out), .busy(busy), .done(done), .overflow(overflow), .rd_ptr(rd_ptr)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_cell(input bit v);
    repeat (H) exp_wave.push_back(1'b1);
    repeat (v ? H : 3*H) exp_wave.push_back(1'b0);
  endtask

  // Sample 0 is the fetch cycle, the final sample is the done cycle.
  task automatic build_exp(input logic [7:0] b[$]);
    exp_wave.delete();
    exp_wave.push_back(1'b0);
    foreach (b[i]) begin
      int ones;
      ones = $countones(b[i]);
      add_cell(1'b0);
      for (int k = 0; k < 8; k++) add_cell(b[i][k]);
      add_cell(ones % 2 == 0);
      repeat (SB) add_cell(1'b1);
    end
    exp_wave.push_back(1'b0);
  endtask

  task automatic download(input logic [7:0] b[$], input int bad_addr);
    int a;
    @(negedge clk_sys);
    dl_active = 1'b1;
    @(negedge clk_sys);
    foreach (b[i]) begin
      a = i;
      dl_wr = 1'b1; dl_addr = a[AW:0]; dl_data = b[i];
      @(negedge clk_sys);
    end
    if (bad_addr >= 0) begin
      dl_wr = 1'b1; dl_addr = bad_addr[AW:0]; dl_data = 8'hEE;
      @(negedge clk_sys);
    end
    dl_wr = 1'b0;
    dl_active = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic run_play(input int pause_at, input int pause_len);
    int idx;
    bit seen;
    cap_tape.delete();
    cap_ptr.delete();
    busy_at_done = 1'b1;
    extra_done = 0;
    idx = 0;
    seen = 1'b0;
    play = 1'b1;
    while (!seen && idx < 6000) begin
      @(negedge clk_sys);
      cap_tape.push_back(tape_out);
      cap_ptr.push_back(int'(rd_ptr));
      if (done) begin
        seen = 1'b1;
        busy_at_done = busy;
      end
      if (idx == pause_at) motor = 1'b0;
      if (idx == pause_at + pause_len) motor = 1'b1;
      idx++;
    end
    play = 1'b0;
    motor = 1'b1;
    timed_out = !seen;
    repeat (3) begin
      @(negedge clk_sys);
      if (done) extra_done++;
    end
  endtask

  task automatic compare_wave(input string name);
    int first_bad;
    first_bad = -1;
    check({name, " timeout"}, int'(timed_out), 0);
    check({name, " samples"}, cap_tape.size(), exp_wave.size());
    foreach (exp_wave[i])
      if (first_bad < 0 && (i >= cap_tape.size() || cap_tape[i] != exp_wave[i])) first_bad = i;
    check({name, " first_bad_sample"}, first_bad, -1);
    check({name, " busy_at_done"}, int'(busy_at_done), 0);
    check({name, " extra_done"}, extra_done, 0);
    if (cap_ptr.size() > 0) check({name, " rd_ptr_at_done"}, cap_ptr[cap_ptr.size()-1], 0);
  endtask

  task automatic check_decoded(input vec_t v);
    int i, hl, ll;
    bit bits[$];
    logic [7:0] d;
    i = 1;
    while (i < cap_tape.size() - 1) begin
      hl = 0; ll = 0;
      while (i < cap_tape.size() - 1 && cap_tape[i]) begin hl++; i++; end
      while (i < cap_tape.size() - 1 && !cap_tape[i]) begin ll++; i++; end
      bits.push_back(ll == H && hl == H);
    end
    check("tbl cells", bits.size(), 9 + 1 + SB);
    if (bits.size() >= 10) begin
      for (int k = 0; k < 8; k++) d[k] = bits[k+1];
      check("tbl start_bit", int'(bits[0]), 0);
      check("tbl data", int'(d), int'(v.data));
      check("tbl parity", int'(bits[9]), int'(v.par));
    end
    check("tbl frame_cycles", cap_tape.size() - 2, v.cycles);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    int pa, pl, first_hi, base, n_busy, n_done;
    bit konst;
    tbl[0] = '{8'h16, 1'b0, 168};
    tbl[1] = '{8'h24, 1'b1, 168};
    tbl[2] = '{8'h00, 1'b1, 184};
    tbl[3] = '{8'hFF, 1'b1, 120};
    tbl[4] = '{8'h01, 1'b0, 184};
    tbl[5] = '{8'hA5, 1'b1, 152};

    repeat (3) @(negedge clk_sys);
    check("reset tape_out", int'(tape_out), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset overflow", int'(overflow), 0);
    check("reset rd_ptr", int'(rd_ptr), 0);
    I_RESET = 1'b1;
    @(negedge clk_sys);

    n_busy = 0;
    play = 1'b1;
    repeat (20) begin @(negedge clk_sys); if (busy) n_busy++; end
    play = 1'b0;
    @(negedge clk_sys);
    check("empty_play busy_cycles", n_busy, 0);

    q = '{8'h16, 8'h24};
    download(q, 16);
    check("overrun overflow", int'(overflow), 1);
    build_exp(q);
    run_play(-1, 0);
    compare_wave("two_byte");
    first_hi = -1;
    foreach (cap_tape[i]) if (first_hi < 0 && cap_tape[i]) first_hi = i;
    check("first_rise_cycles", first_hi + 1, 2);
    if (cap_ptr.size() > 170) begin
      check("rd_ptr byte0_last", cap_ptr[168], 0);
      check("rd_ptr byte1_first", cap_ptr[169], 1);
    end

    build_exp(q);
    base = exp_wave.size();
    for (int k = 0; k < 50; k++) exp_wave.insert(41, exp_wave[40]);
    run_play(40, 50);
    compare_wave("motor_pause");
    check("motor total_samples", cap_tape.size() - base, 50);
    konst = 1'b1;
    if (cap_tape.size() > 91) for (int k = 41; k <= 90; k++) if (cap_tape[k] != cap_tape[40]) konst = 1'b0;
    check("motor tape_constant", int'(konst), 1);

    foreach (tbl[t]) begin
      q = '{tbl[t].data};
      download(q, -1);
      build_exp(q);
      run_play(-1, 0);
      compare_wave("tbl wave");
      check_decoded(tbl[t]);
    end

    for (int r = 0; r < 8; r++) begin
      q.delete();
      repeat ($urandom_range(1, 5)) q.push_back(8'($urandom));
      download(q, ($urandom_range(0, 1) == 1) ? 16 + $urandom_range(0, 15) : -1);
      build_exp(q);
      pa = -1; pl = 0;
      if (r % 2 == 1) begin
        pa = $urandom_range(5, exp_wave.size() - 5);
        pl = $urandom_range(1, 30);
        for (int k = 0; k < pl; k++) exp_wave.insert(pa + 1, exp_wave[pa]);
      end
      run_play(pa, pl);
      compare_wave("random");
    end

    q = '{8'h16, 8'h24};
    download(q, -1);
    play = 1'b1;
    repeat (126) @(negedge clk_sys);
    check("stop busy_before", int'(busy), 1);
    stop = 1'b1;
    @(negedge clk_sys);
    check("stop busy", int'(busy), 0);
    check("stop tape_out", int'(tape_out), 0);
    check("stop rd_ptr", int'(rd_ptr), 0);
    check("stop done", int'(done), 0);
    play = 1'b0;
    @(negedge clk_sys);
    play = 1'b1;
    @(negedge clk_sys);
    check("stop_overrides_play busy", int'(busy), 0);
    stop = 1'b0; play = 1'b0;
    n_done = 0;
    repeat (300) begin @(negedge clk_sys); if (done) n_done++; end
    check("stop no_done", n_done, 0);

    download(q, 17);
    play = 1'b1;
    repeat (148) @(negedge clk_sys);
    check("abort tape_before", int'(tape_out), 1);
    dl_active = 1'b1;
    @(negedge clk_sys);
    check("abort busy_load", int'(busy), 1);
    check("abort tape_out", int'(tape_out), 0);
    check("abort rd_ptr", int'(rd_ptr), 0);
    check("abort overflow_cleared", int'(overflow), 0);
    dl_active = 1'b0; play = 1'b0;
    @(negedge clk_sys);
    check("abort idle", int'(busy), 0);
    n_busy = 0;
    play = 1'b1;
    repeat (20) begin @(negedge clk_sys); if (busy) n_busy++; end
    play = 1'b0;
    check("abort length_cleared", n_busy, 0);

    q = '{8'h16};
    download(q, 20);
    play = 1'b1;
    repeat (35) @(negedge clk_sys);
    check("reset_mid tape_before", int'(tape_out), 1);
    check("reset_mid overflow_before", int'(overflow), 1);
    #2 I_RESET = 1'b0;
    #1;
    check("reset_mid tape_out", int'(tape_out), 0);
    check("reset_mid busy", int'(busy), 0);
    check("reset_mid done", int'(done), 0);
    check("reset_mid overflow", int'(overflow), 0);
    check("reset_mid rd_ptr", int'(rd_ptr), 0);
    @(negedge clk_sys);
    I_RESET = 1'b1; play = 1'b0;
    @(negedge clk_sys);
    n_busy = 0;
    play = 1'b1;
    repeat (20) begin @(negedge clk_sys); if (busy) n_busy++; end
    play = 1'b0;
    check("reset_mid needs_reload", n_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
